// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals shared by the
// core/debug memory port arbiter and whatever drives it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // core requester
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  // debug / loader requester
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  // shared synchronous memory
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              dbg_starved;

  // Arbiter side: takes requests and memory read data, drives the rest.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output core_gnt, core_rvalid, core_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata,
    output dbg_starved
  );

  // Environment side: requesters plus the memory's read data.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    input  dbg_starved
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (core, debug) in front of one synchronous data
// memory. Core has priority; a debug requester that has lost MAX_WAIT
// cycles in a row overrides it. Read data is steered back one cycle later
// by a registered return tag, so a new grant can issue every cycle.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_owner_q, tag_owner_d;   // 1 = debug owns the return
  logic       starved;
  logic       core_win, dbg_win;

  assign starved = (wait_cnt_q == MAX_WAIT_C);

  // Grant decision for this cycle; nothing is granted while reset is high.
  always_comb begin
    core_win = 1'b0;
    dbg_win  = 1'b0;
    if (!reset) begin
      if (bus.core_req && bus.dbg_req) begin
        if (starved) dbg_win  = 1'b1;
        else         core_win = 1'b1;
      end else if (bus.core_req) begin
        core_win = 1'b1;
      end else if (bus.dbg_req) begin
        dbg_win = 1'b1;
      end
    end
  end

  // Route the winner onto the memory bus; idle bus is all zeros.
  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (core_win) begin
      bus.mem_re    = ~bus.core_we;
      bus.mem_we    = bus.core_we;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
    end else if (dbg_win) begin
      bus.mem_re    = ~bus.dbg_we;
      bus.mem_we    = bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

  // Next-state for the starvation counter and the read return tag.
  always_comb begin
    wait_cnt_d = 4'd0;
    if (bus.dbg_req && !dbg_win) begin
      wait_cnt_d = (wait_cnt_q < MAX_WAIT_C) ? wait_cnt_q + 4'd1 : wait_cnt_q;
    end
    tag_valid_d = (core_win && !bus.core_we) || (dbg_win && !bus.dbg_we);
    tag_owner_d = dbg_win;
  end

  // State registers; reset drops the counter and any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= 4'd0;
      tag_valid_q <= 1'b0;
      tag_owner_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  assign bus.core_gnt    = core_win;
  assign bus.dbg_gnt     = dbg_win;
  assign bus.dbg_starved = starved;

  // Read data goes only to the tag owner; the other port sees zeros.
  assign bus.core_rvalid = tag_valid_q & ~tag_owner_q;
  assign bus.dbg_rvalid  = tag_valid_q & tag_owner_q;
  assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
  assign bus.dbg_rdata   = bus.dbg_rvalid  ? bus.mem_rdata : '0;

endmodule
